seq_multiplier_nb: RTL
======================

# seq_multiplier_nb

Parametrised sequential shift-and-add multiplier with valid/ready handshakes on both operand and result sides. Supports a per-operation unsigned or two's-complement mode. It is the area-reduced, width-generic successor to the fixed 4-bit combinational array multiplier in the datapath library. It sits between an operand producer and a result consumer that may stall.

## Interface
- `WIDTH`, default 8: operand width in bits, legal range 2–32; the product is 2·WIDTH bits.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present on `a`, `b`, `signed_mode`.
- `in_ready`  out  1  block can accept operands this cycle.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `signed_mode`  in  1  1 = treat `a`/`b` as two's complement, 0 = unsigned; sampled with the operands.
- `out_valid`  out  1  `product` holds a finished result.
- `out_ready`  in  1  consumer accepts the result.
- `product`  out  2·WIDTH  registered result.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`=1, the following are captured at the edge: multiplicand and multiplier magnitudes (in signed mode, negate any operand whose MSB is 1), `neg` = `signed_mode` & (a[MSB] ^ b[MSB]), accumulator = 0, and bit counter = 0. The FSM then moves to CALC.
- CALC, one multiplier bit per cycle:
  - If the multiplier LSB is 1, upper accumulator half += multiplicand (WIDTH+1-bit sum including carry).
  - Then {carry, acc_hi, multiplier} is shifted right by 1 and the counter increments.
  - After exactly WIDTH iterations the FSM moves to FIX.
- FIX:
  - If `neg`=1, the product is replaced by its 2·WIDTH-bit two's-complement negation; otherwise it is unchanged.
  - The result is loaded into `product` and the FSM moves to DONE.
- DONE:
  - `out_valid`=1, and `product` is held stable.
  - When `out_ready`=1, the FSM moves to IDLE, `out_valid` drops, and `product` keeps its last value.
- Width rules:
  - Unsigned results are exact over 0..(2^WIDTH−1)².
  - Signed magnitudes use WIDTH bits unsigned, so −2^(WIDTH−1) (magnitude 2^(WIDTH−1)) is exact.
  - (−2^(WIDTH−1))² = 2^(2·WIDTH−2) fits a signed 2·WIDTH-bit result.
- `in_valid` outside IDLE is ignored; operands are not buffered.
- `in_ready` is combinational: (state==IDLE) & ~`reset`.

## Timing
- Reset values: state IDLE, `out_valid`=0, `product`=0, accumulator/counter=0, `in_ready`=0 while `reset` is high.
- Latency: with the operand accepted at the end of cycle 0, `out_valid` is first high in cycle WIDTH+2 (cycle 10 for WIDTH=8).
- Throughput: with `out_ready` held high, one operation per WIDTH+3 cycles (DONE → IDLE takes one cycle; there is no accept in DONE).
- Backpressure: DONE persists indefinitely while `out_ready`=0, with `product` bit-stable.
- Reset mid-operation (any state): at the next edge everything returns to reset values, the in-flight result is discarded, and a new operand may be accepted the cycle after `reset` deasserts.
- `reset` has priority over all handshakes in the same cycle.

## Structure
- The shared package/header holds:
  - FSM state encodings (2-bit).
  - The counter-width function ceil(log2(WIDTH+1)).
- The WIDTH+1-bit addition is a natural sub-module, `ripple_adder_nb` (parametrised, with carry-in/carry-out). The same sub-module also performs the FIX negation (invert + carry-in 1, 2·WIDTH wide instance).
- Estimated size: FSM, datapath registers and handshake logic total roughly 150–250 RTL lines.

## Test plan
- Unsigned, WIDTH=8, a=255, b=255: `product`=0xFE01, `out_valid` in cycle 10 after accept; a=0, b=0xAB gives 0x0000.
- Signed: −3×5 gives 0xFFF1; −128×−128 gives 0x4000; −128×127 gives 0xC080; 127×127 gives 0x3F01.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE: `product` stays stable, `in_ready`=0, and `in_valid` pulses are ignored.
  - Then `out_ready`=1: the result is accepted once and IDLE follows.
- Reset in the 4th CALC cycle: the next cycle shows IDLE, `out_valid`=0 and `product`=0. A following 12×13 unsigned operation gives 0x009C.
- Back-to-back random operands with `out_ready`=1, 1000 ops each at WIDTH=4, 8 and 16: results match a reference model, and the accept period is exactly WIDTH+3 cycles.

Source files
------------

// File: rtl/seq_multiplier_nb_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_multiplier_nb_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bits needed to count 0..w inclusive: ceil(log2(w+1))
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_nb_if.sv
// Operand/result handshake bundle for seq_multiplier_nb.
interface seq_multiplier_nb_if #(
  parameter int unsigned WIDTH = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   signed_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;

  // Producer/consumer side
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product
  );

  // Multiplier side
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/ripple_adder_nb.sv
// Parametrised ripple-carry adder with carry-in and carry-out.
module ripple_adder_nb #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  // Bit-serial carry chain
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[N];
  end

endmodule

// File: rtl/seq_multiplier_nb.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle,
// unsigned or two's-complement per operation, valid/ready on both sides.
module seq_multiplier_nb
  import seq_multiplier_nb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_multiplier_nb_if.slave io
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [WIDTH-1:0]  acc_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic [PW-1:0]     product_q;

  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic [WIDTH-1:0]  add_sum;
  logic              add_cout;
  logic [WIDTH:0]    step_sum;
  logic [PW-1:0]     neg_prod;
  logic              neg_cout_unused;
  logic              last_iter;

  // Operand magnitudes; in signed mode negative operands are negated so
  // the most negative value maps to an exact unsigned magnitude
  always_comb begin
    mag_a = io.a;
    mag_b = io.b;
    if (io.signed_mode && io.a[WIDTH-1]) mag_a = (~io.a) + WIDTH'(1);
    if (io.signed_mode && io.b[WIDTH-1]) mag_b = (~io.b) + WIDTH'(1);
  end

  // Partial-product accumulate: acc_hi + multiplicand with carry out
  ripple_adder_nb #(.N(WIDTH)) u_acc_add (
    .a    (acc_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Final two's-complement negation: invert plus carry-in
  ripple_adder_nb #(.N(PW)) u_neg_add (
    .a    (~{acc_q, mplier_q}),
    .b    ({PW{1'b0}}),
    .cin  (1'b1),
    .sum  (neg_prod),
    .cout (neg_cout_unused)
  );

  // Carry-extended step value before the right shift
  always_comb begin
    step_sum  = mplier_q[0] ? {add_cout, add_sum} : {1'b0, acc_q};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (io.in_valid)  state_d = ST_CALC;
      ST_CALC: if (last_iter)    state_d = ST_FIX;
      ST_FIX:                    state_d = ST_DONE;
      ST_DONE: if (io.out_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    io.in_ready  = (state_q == ST_IDLE) & ~reset;
    io.out_valid = (state_q == ST_DONE);
  end

  assign io.product = product_q;

  // Datapath: capture, shift-add iterations, sign fix-up and result load
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.in_valid) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= io.signed_mode & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
          end
        end
        ST_CALC: begin
          acc_q    <= step_sum[WIDTH:1];
          mplier_q <= {step_sum[0], mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CW'(1);
        end
        ST_FIX: begin
          product_q <= neg_q ? neg_prod : {acc_q, mplier_q};
        end
        default: ;
      endcase
    end
  end

endmodule
